// File: rtl/sram_dma_sched_if.sv
// ============================================================================
//  Module      : sram_dma_sched_if
//  Description : 6502 bus slot, DMA control and SRAM pin bundle for the
//                SRAM DMA slot scheduler.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface sram_dma_sched_if;
    logic        BusReq;
    logic        BusWE;
    logic [19:0] BusA;
    logic        DmaStart;
    logic        DmaAbort;
    logic        DmaFill;
    logic [19:0] DmaSrc;
    logic [19:0] DmaDst;
    logic [15:0] DmaLen;
    logic [7:0]  FillVal;
    logic [7:0]  RDin;
    logic [19:0] SA;
    logic        nSCS;
    logic        nSWE;
    logic        RDOE;
    logic [7:0]  RDout;
    logic        Busy;
    logic        Done;

    modport master (
        output BusReq, BusWE, BusA, DmaStart, DmaAbort, DmaFill,
               DmaSrc, DmaDst, DmaLen, FillVal, RDin,
        input  SA, nSCS, nSWE, RDOE, RDout, Busy, Done
    );

    modport slave (
        input  BusReq, BusWE, BusA, DmaStart, DmaAbort, DmaFill,
               DmaSrc, DmaDst, DmaLen, FillVal, RDin,
        output SA, nSCS, nSWE, RDOE, RDout, Busy, Done
    );
endinterface

`default_nettype wire

// File: rtl/sram_dma_sched.sv
// ============================================================================
//  Module      : sram_dma_sched
//  Description : Splits each Apple cycle into DMA slots (S1-S3) and 6502 bus
//                slots (S4-S7); moves one byte per cycle (copy or fill).
//                Fill mode is built only when SRAM_DMA_FILL_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module sram_dma_sched (
    input  wire logic       C7M,
    input  wire logic       nRES,
    input  wire logic       PHI1,
    sram_dma_sched_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } state_t;

    localparam logic [2:0] c_SLOT_MAX = 3'd7;

    state_t      r_state;
    state_t      w_state_nx;
    logic [2:0]  r_slot;
    logic        r_phi1_d;
    logic        r_seen;
    logic [19:0] r_src;
    logic [19:0] r_dst;
    logic [15:0] r_cnt;
    logic        r_fill;
    logic [7:0]  r_data;
    logic        r_stepok;
    logic        r_done;

    logic        w_accept;
    logic        w_latch;
    logic        w_adv;
    logic        w_done_nx;
    logic        w_fill_sel;
    logic [7:0]  w_fill_val;
    logic [19:0] w_sa;
    logic        w_nscs;
    logic        w_nswe;
    logic        w_rdoe;

`ifdef SRAM_DMA_FILL_EN
    assign w_fill_sel = bus.DmaFill;
    assign w_fill_val = bus.FillVal;
`else
    logic w_unused_fill;
    assign w_fill_sel    = 1'b0;
    assign w_fill_val    = 8'h00;
    assign w_unused_fill = ^{bus.DmaFill, bus.FillVal};
`endif

    // Slot 1 only on a PHI1 rise that follows a genuinely observed low phase.
    always_ff @(posedge C7M or negedge nRES) begin
        if (!nRES) begin
            r_slot   <= 3'd0;
            r_phi1_d <= 1'b0;
            r_seen   <= 1'b0;
        end else begin
            r_phi1_d <= PHI1;
            if (!PHI1)
                r_seen <= 1'b1;
            if (PHI1 && !r_phi1_d && r_seen)
                r_slot <= 3'd1;
            else if (r_slot != 3'd0 && r_slot != c_SLOT_MAX)
                r_slot <= r_slot + 3'd1;
        end
    end

    always_ff @(posedge C7M or negedge nRES) begin
        if (!nRES)
            r_state <= IDLE;
        else
            r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        w_accept   = 1'b0;
        w_latch    = 1'b0;
        w_adv      = 1'b0;
        w_done_nx  = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.DmaStart) begin
                    if (bus.DmaLen != 16'd0) begin
                        w_state_nx = RD;
                        w_accept   = 1'b1;
                    end else begin
                        w_done_nx  = 1'b1;
                    end
                end
            end
            RD: begin
                if (bus.DmaAbort) begin
                    w_state_nx = IDLE;
                    w_done_nx  = 1'b1;
                end else if (r_slot == 3'd2 && r_stepok) begin
                    w_state_nx = WR;
                    w_latch    = 1'b1;
                end
            end
            WR: begin
                if (bus.DmaAbort) begin
                    w_state_nx = IDLE;
                    w_done_nx  = 1'b1;
                end else if (r_slot == 3'd3) begin
                    w_adv = 1'b1;
                    if (r_cnt == 16'd1) begin
                        w_state_nx = IDLE;
                        w_done_nx  = 1'b1;
                    end else begin
                        w_state_nx = RD;
                    end
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    // r_stepok marks that the current step really started in S1.
    always_ff @(posedge C7M or negedge nRES) begin
        if (!nRES) begin
            r_src    <= 20'd0;
            r_dst    <= 20'd0;
            r_cnt    <= 16'd0;
            r_fill   <= 1'b0;
            r_data   <= 8'h00;
            r_stepok <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done   <= w_done_nx;
            r_stepok <= (w_state_nx == RD) && (r_state == RD) &&
                        (r_stepok || r_slot == 3'd1);
            if (w_accept) begin
                r_src  <= bus.DmaSrc;
                r_dst  <= bus.DmaDst;
                r_cnt  <= bus.DmaLen;
                r_fill <= w_fill_sel;
                r_data <= w_fill_val;
            end
            if (w_latch && !r_fill)
                r_data <= bus.RDin;
            if (w_adv) begin
                r_src <= r_src + 20'd1;
                r_dst <= r_dst + 20'd1;
                r_cnt <= r_cnt - 16'd1;
            end
        end
    end

    always_comb begin
        w_sa   = 20'd0;
        w_nscs = 1'b1;
        w_nswe = 1'b1;
        w_rdoe = 1'b0;
        case (r_slot)
            3'd1, 3'd2: begin
                if (r_state == RD && !r_fill && (r_slot == 3'd1 || r_stepok)) begin
                    w_sa   = r_src;
                    w_nscs = 1'b0;
                end
            end
            3'd3: begin
                if (r_state == WR) begin
                    w_sa   = r_dst;
                    w_nscs = 1'b0;
                    w_nswe = 1'b0;
                    w_rdoe = 1'b1;
                end
            end
            3'd4, 3'd5, 3'd6, 3'd7: begin
                w_sa = bus.BusA;
                if (r_slot >= 3'd5)
                    w_nscs = ~bus.BusReq;
                if (r_slot >= 3'd6)
                    w_nswe = ~(bus.BusReq & bus.BusWE);
            end
            default: ;
        endcase
    end

    assign bus.SA    = w_sa;
    assign bus.nSCS  = w_nscs;
    assign bus.nSWE  = w_nswe;
    assign bus.RDOE  = w_rdoe;
    assign bus.RDout = r_data;
    assign bus.Busy  = (r_state != IDLE);
    assign bus.Done  = r_done;
endmodule

`default_nettype wire
